// File: rtl/mod_mul_pkg.sv
// Shared constants and types for the BLS12-377 base-field interleaved multiplier.
package mod_mul_pkg;

  localparam int P_WIDTH = 377;
  localparam logic [P_WIDTH-1:0] P =
    377'h01ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001;
  localparam int CNT_W = $clog2(P_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mm_state_t;

endpackage

// File: rtl/mod_dbl_add_step.sv
// One MSB-first interleaved step: acc_next = (2*acc + (bit_in ? a : 0)) mod P.
// Kept separate so a pipelined or carry-save step can be swapped in.
module mod_dbl_add_step #(
  parameter int                 P_WIDTH = 377,
  parameter logic [P_WIDTH-1:0] P       = '1
) (
  input  logic [P_WIDTH-1:0] acc,
  input  logic [P_WIDTH-1:0] a,
  input  logic               bit_in,
  output logic [P_WIDTH-1:0] acc_next
);

  localparam int TW = P_WIDTH + 2;
  localparam logic [TW-1:0] P_EXT = {2'b00, P};

  logic [TW-1:0] t_sum;
  logic [TW-1:0] t_red1;

  // With acc < P and a < P the sum is below 3P, so two subtracts fully reduce it.
  always_comb begin
    t_sum  = {1'b0, acc, 1'b0} + (bit_in ? {2'b00, a} : '0);
    t_red1 = (t_sum >= P_EXT) ? (t_sum - P_EXT) : t_sum;
    acc_next = (t_red1 >= P_EXT) ? P_WIDTH'(t_red1 - P_EXT) : P_WIDTH'(t_red1);
  end

endmodule

// File: rtl/interleaved_mod_mul.sv
// Iterative modular multiplier r = a*b mod P, one multiplier bit per clock, MSB first.
// State | meaning: IDLE wait for enable | RUN one bit per cycle | DONE one-cycle result pulse.
module interleaved_mod_mul #(
  parameter int                 P_WIDTH = mod_mul_pkg::P_WIDTH,
  parameter logic [P_WIDTH-1:0] P       = mod_mul_pkg::P
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] r,
  output logic               done,
  output logic               busy
);

  import mod_mul_pkg::mm_state_t;
  import mod_mul_pkg::IDLE;
  import mod_mul_pkg::RUN;
  import mod_mul_pkg::DONE;

  localparam int CW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;

  mm_state_t          state_q, state_d;
  logic [P_WIDTH-1:0] a_q, a_d;
  logic [P_WIDTH-1:0] b_q, b_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [P_WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [P_WIDTH-1:0] step_out;

  mod_dbl_add_step #(
    .P_WIDTH (P_WIDTH),
    .P       (P)
  ) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .bit_in   (b_q[cnt_q]),
    .acc_next (step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = CW'(P_WIDTH - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_out;
        // The counter parks at zero so it never wraps while idle.
        if (cnt_q == '0) begin
          r_d     = step_out;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign r    = r_q;
  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_interleaved_mod_mul.sv
// Self-checking bench: directed operations, scoreboard of expected results and capture cycles.
module tb_interleaved_mod_mul;

  localparam int PW = 377;
  localparam logic [PW-1:0] PM = mod_mul_pkg::P;
  localparam int LAT = 377;
  localparam int THRU = 379;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] a_i = '0;
  logic [PW-1:0] b_i = '0;
  logic [PW-1:0] r_o;
  logic          done_o;
  logic          busy_o;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  logic [PW-1:0] exp_q[$];
  longint        start_q[$];

  interleaved_mod_mul dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .a      (a_i),
    .b      (b_i),
    .r      (r_o),
    .done   (done_o),
    .busy   (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [379:0] obs, input logic [379:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // LSB-first add-and-double reference, independent of the DUT's MSB-first order.
  function automatic logic [PW-1:0] ref_mul(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW+1:0] acc;
    logic [PW+1:0] add;
    acc = '0;
    add = {2'b00, x};
    for (int i = 0; i < PW; i++) begin
      if (y[i]) begin
        acc = acc + add;
        if (acc >= {2'b00, PM}) acc = acc - {2'b00, PM};
      end
      add = add << 1;
      if (add >= {2'b00, PM}) add = add - {2'b00, PM};
    end
    return acc[PW-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        logic [PW-1:0] e;
        longint s;
        e = exp_q.pop_front();
        s = start_q.pop_front();
        chk("result", r_o, e);
        chk("latency", cyc - s, LAT);
      end
    end
  end

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic capture(input logic [PW-1:0] x, input logic [PW-1:0] y);
    @(negedge clk);
    a_i = x;
    b_i = y;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic run_op(input logic [PW-1:0] x, input logic [PW-1:0] y, input logic [PW-1:0] e);
    capture(x, y);
    exp_q.push_back(e);
    start_q.push_back(cyc);
    chk("busy_after_start", busy_o, 1);
    wait_done();
    chk("busy_in_done", busy_o, 1);
    @(negedge clk);
    chk("done_one_cycle", done_o, 0);
    chk("busy_after_done", busy_o, 0);
  endtask

  logic [PW-1:0] ha, hb, ra, rb;
  logic [383:0]  rnd;

  initial begin
    ha = 377'h1647170e013bf53a7b050468f43383b17361703bef0431b3f0f3ddad4af519168f4af9b29e96740671f4fbb2b93eb11;
    hb = 377'h144b5478f0886377ee7fe272cd4ca5a12f1e38816016588cffe3240b0776a00199763223e90b4b30d4f21c3d098f416;

    repeat (2) @(negedge clk);
    chk("reset_r", r_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_busy", busy_o, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3, 5, 15);
    run_op(PM - 1, PM - 1, 1);
    run_op(PM - 1, 2, PM - 2);
    run_op(0, PM - 1, 0);
    run_op(PM - 1, 0, 0);
    run_op(1, hb, hb);

    // Level-held enable: back-to-back captures every THRU cycles.
    @(negedge clk);
    a_i = ha;
    b_i = hb;
    enable = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(ref_mul(ha, hb));
    start_q.push_back(cyc);
    exp_q.push_back(ref_mul(ha, hb));
    start_q.push_back(cyc + THRU);
    wait_done();
    @(negedge clk);
    chk("held_idle_gap_busy", busy_o, 0);
    wait_done();
    enable = 1'b0;
    @(negedge clk);
    chk("held_busy_end", busy_o, 0);

    // Operand and enable changes during RUN/DONE must be ignored.
    capture(7, 9);
    exp_q.push_back(63);
    start_q.push_back(cyc);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      enable = ~enable;
      a_i = PW'($urandom);
      b_i = PW'($urandom);
    end
    repeat (350) @(negedge clk);
    enable = 1'b1;
    wait_done();
    enable = 1'b0;
    @(negedge clk);
    chk("no_restart_busy", busy_o, 0);
    @(negedge clk);
    chk("still_idle_busy", busy_o, 0);

    // Asynchronous reset mid-operation.
    capture(5, 7);
    repeat (200) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_done", done_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_r", r_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", busy_o, 0);
    run_op(2, 3, 6);

    for (int k = 0; k < 12; k++) rnd[k*32 +: 32] = $urandom;
    ra = {1'b0, rnd[PW-2:0]};
    for (int k = 0; k < 12; k++) rnd[k*32 +: 32] = $urandom;
    rb = {1'b0, rnd[PW-2:0]};
    run_op(ra, rb, ref_mul(ra, rb));

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
